lfsr_seq_ctrl: RTL and testbench

// - Sequencer for a Fibonacci LFSR: loads a seed, steps it a requested number of

---
 rtl/lfsr_seq_ctrl.sv | 112 +++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// Fibonacci LFSR sequencer: seeds, steps and streams bits under valid/ready.
// Optional LFSR_SEQ_ZERO_SEED_FIX_EN: substitute an all-zero seed instead of rejecting it.
module lfsr_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'hB8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] nbits,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] state_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LFSR_RST = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             seed_zero;
    logic             fb;
    logic             last_bit;

    assign seed_zero = (seed == '0);
    assign fb        = ^(lfsr_q & TAP_MASK);
    assign last_bit  = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef LFSR_SEQ_ZERO_SEED_FIX_EN
                    lfsr_d  = seed_zero ? LFSR_RST : seed;
                    cnt_d   = nbits;
                    err_d   = 1'b0;
                    state_d = (nbits == '0) ? S_DONE : S_RUN;
`else
                    if (seed_zero) begin
                        // rejected: register keeps its previous value
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        lfsr_d  = seed;
                        cnt_d   = nbits;
                        err_d   = 1'b0;
                        state_d = (nbits == '0) ? S_DONE : S_RUN;
                    end
`endif
                end
            end
            S_RUN: begin
                if (bit_ready) begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (last_bit || cnt_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_RST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bit_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign bit_out   = lfsr_q[WIDTH-1];
    assign state_out = lfsr_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with WIDTH=4, TAPS=4'hC (x^4+x^3+1).
module tb_lfsr_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  seed;
    logic [CW-1:0] nbits;
    logic          bit_out;
    logic          bit_valid;
    logic          bit_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(
        .WIDTH(W),
        .TAPS (32'hC),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed     (seed),
        .nbits    (nbits),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .state_out(state_out)
    );

    typedef struct {
        logic [3:0]  seed;
        logic [15:0] nbits;
        bit          stall;
        int          n_exp;
        logic [15:0] bits;
        logic [3:0]  fin;
        logic        e;
        int          cyc;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [15:0] got;
        int          nx;
        int          cyc;
        int          done_it;
        bit          prev_stall;
        logic        pbit;
        logic [3:0]  pstate;
        bit          rdy;
        got        = '0;
        nx         = 0;
        cyc        = 0;
        done_it    = -1;
        prev_stall = 1'b0;
        pbit       = 1'b0;
        pstate     = '0;
        seed       = v.seed;
        nbits      = v.nbits;
        bit_ready  = !v.stall;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d first_valid", id), 32'(bit_valid), 32'(v.cyc > 0));
        for (int it = 0; it < 64 && done_it < 0; it++) begin
            if (done) begin
                done_it = it;
                chk($sformatf("v%0d state_at_done", id), 32'(state_out), 32'(v.fin));
                chk($sformatf("v%0d err_at_done", id), 32'(err), 32'(v.e));
                chk($sformatf("v%0d valid_at_done", id), 32'(bit_valid), 32'd0);
            end else begin
                if (bit_valid) begin
                    rdy = v.stall ? bit'(cyc[0]) : 1'b1;
                    if (prev_stall) begin
                        chk($sformatf("v%0d stall_hold", id),
                            32'({bit_out, state_out}), 32'({pbit, pstate}));
                    end
                    chk($sformatf("v%0d busy", id), 32'(busy), 32'd1);
                    bit_ready = rdy;
                    if (rdy && nx < 16) begin
                        got[nx] = bit_out;
                        nx++;
                    end
                    prev_stall = !rdy;
                    pbit       = bit_out;
                    pstate     = state_out;
                    cyc++;
                end
                @(posedge clk);
                #1;
            end
        end
        chk($sformatf("v%0d done_latency", id), 32'(done_it), 32'(v.cyc));
        chk($sformatf("v%0d transfers", id), 32'(nx), 32'(v.n_exp));
        chk($sformatf("v%0d bits", id), 32'(got), 32'(v.bits));
        chk($sformatf("v%0d run_cycles", id), 32'(cyc), 32'(v.cyc));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d done_pulse_once", id), 32'(done), 32'd0);
        chk($sformatf("v%0d idle_busy", id), 32'(busy), 32'd0);
        chk($sformatf("v%0d state_held", id), 32'(state_out), 32'(v.fin));
        chk($sformatf("v%0d err_held", id), 32'(err), 32'(v.e));
        bit_ready = 1'b0;
    endtask

    initial begin
        // bit i of .bits is the i-th emitted bit; seed 1 walks 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8
        vt[0] = '{4'h1, 16'd6,  1'b0, 6,  16'h0008, 4'hD, 1'b0, 6};
        vt[1] = '{4'h1, 16'd15, 1'b0, 15, 16'h7AC8, 4'h1, 1'b0, 15};
        vt[2] = '{4'h1, 16'd6,  1'b1, 6,  16'h0008, 4'hD, 1'b0, 12};
        vt[3] = '{4'hB, 16'd3,  1'b0, 3,  16'h0005, 4'hE, 1'b0, 3};
        vt[4] = '{4'h9, 16'd0,  1'b0, 0,  16'h0000, 4'h9, 1'b0, 0};
`ifdef LFSR_SEQ_ZERO_SEED_FIX_EN
        vt[5] = '{4'h0, 16'd6,  1'b0, 6,  16'h0008, 4'hD, 1'b0, 6};
        vt[6] = '{4'h8, 16'd2,  1'b0, 2,  16'h0001, 4'h2, 1'b0, 2};
`else
        vt[5] = '{4'h0, 16'd6,  1'b0, 0,  16'h0000, 4'h9, 1'b1, 0};
        vt[6] = '{4'h1, 16'd2,  1'b0, 2,  16'h0000, 4'h4, 1'b0, 2};
`endif

        rst       = 1'b1;
        start     = 1'b0;
        seed      = '0;
        nbits     = '0;
        bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(state_out), 32'h1);
        chk("reset_flags", 32'({bit_valid, busy, done, err}), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i], i);
            @(posedge clk);
            #1;
        end

        // abort mid-run, with an ignored start issued while running
        seed      = 4'h1;
        nbits     = 16'd6;
        bit_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        seed  = 4'hF;
        nbits = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t6 ignore_start_state", 32'(state_out), 32'h2);
        chk("t6 ignore_start_valid", 32'(bit_valid), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6 after3_state", 32'(state_out), 32'h9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6 rst_valid", 32'(bit_valid), 32'd0);
        chk("t6 rst_busy", 32'(busy), 32'd0);
        chk("t6 rst_state", 32'(state_out), 32'h1);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (done) seen = 1'b1;
                @(posedge clk);
                #1;
            end
            chk("t6 no_done", 32'(seen), 32'd0);
        end
        chk("t6 idle_state", 32'(state_out), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
